// File: rtl/wfg_mem_pkg.sv
// wfg_mem_pkg: stimulus SRAM geometry and arbiter state encoding shared by reader, loader and arbiter
//   MEM_ADDR_W  SRAM word address width
//   MEM_DATA_W  SRAM data width
//   arb_state_e arbiter FSM states
package wfg_mem_pkg;
    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 32;
    typedef enum logic {ST_IDLE, ST_OWNED} arb_state_e;
endpackage

// File: rtl/wfg_mem_arbiter_if.sv
// wfg_mem_arbiter_if: requester-side request/response bus of the stimulus SRAM arbiter
//   req_valid_i/req_we_i  per-requester request valid and write flag
//   req_addr_i/req_wdata_i/req_wmask_i  packed per-requester address, data, byte mask
//   req_ready_o  one-hot grant, rsp_valid_o one-hot read response, rsp_rdata_o shared read data
//   master modport = requesters, slave modport = arbiter
interface wfg_mem_arbiter_if
    import wfg_mem_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ-1:0]            req_we_i;
    logic [NUM_REQ*ADDR_W-1:0]     req_addr_i;
    logic [NUM_REQ*DATA_W-1:0]     req_wdata_i;
    logic [NUM_REQ*(DATA_W/8)-1:0] req_wmask_i;
    logic [NUM_REQ-1:0]            rsp_valid_o;
    logic [DATA_W-1:0]             rsp_rdata_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o
    );
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o
    );
endinterface

// File: rtl/wfg_rr_pick.sv
// wfg_rr_pick: combinational round-robin picker
//   valid_i  request mask, start_i first index searched, excl_i indices never picked
//   gnt_o    one-hot winner, idx_o winner index, any_o a winner exists
module wfg_rr_pick #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] start_i,
    input  logic [N-1:0]  excl_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    logic [N-1:0] cand;

    always_comb begin
        cand  = valid_i & ~excl_i;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && cand[(int'(start_i) + k) % N]) begin
                any_o = 1'b1;
                idx_o = IW'((int'(start_i) + k) % N);
                gnt_o[(int'(start_i) + k) % N] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wfg_mem_arbiter.sv
// wfg_mem_arbiter: round-robin arbiter with bounded bursts for the single-port stimulus SRAM
//   clk, rst      clock, synchronous active-high reset
//   ctrl_en_i     enable; low blocks new grants
//   bus           requester handshake and read response (slave modport)
//   busy_o        owner held or read response pending
//   csb0, web0, wmask0, addr0, din0, dout0  SRAM port
module wfg_mem_arbiter
    import wfg_mem_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ctrl_en_i,
    wfg_mem_arbiter_if.slave    bus,
    output logic                busy_o,
    output logic                csb0,
    output logic                web0,
    output logic [DATA_W/8-1:0] wmask0,
    output logic [ADDR_W-1:0]   addr0,
    output logic [DATA_W-1:0]   din0,
    input  logic [DATA_W-1:0]   dout0
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int MW = DATA_W / 8;
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      last_q, last_d, pend_own_q, pend_own_d;
    logic [BW-1:0]      burst_q, burst_d;
    logic               pend_q, pend_d;
    logic [NUM_REQ-1:0] valid, excl, pick_gnt, gnt;
    logic [IW-1:0]      start, pick_idx, gnt_idx;
    logic               pick_any, any_gnt, keep, owned, rsp_v;

    // While owned, the owner is always the last accepted requester, so last_q doubles as owner.
    always_comb begin
        owned = state_q == ST_OWNED;
        valid = bus.req_valid_i & {NUM_REQ{ctrl_en_i & ~rst}};
        start = (last_q == IW'(NUM_REQ - 1)) ? '0 : last_q + 1'b1;
        excl  = owned ? NUM_REQ'(1) << last_q : '0;
    end

    wfg_rr_pick #(.N(NUM_REQ)) u_pick (
        .valid_i (valid),
        .start_i (start),
        .excl_i  (excl),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        keep       = owned && valid[last_q] && (burst_q != BURST_LAST || !pick_any);
        gnt        = keep ? excl : pick_gnt;
        gnt_idx    = keep ? last_q : pick_idx;
        any_gnt    = keep | pick_any;
        state_d    = any_gnt ? ST_OWNED : ST_IDLE;
        last_d     = any_gnt ? gnt_idx : last_q;
        burst_d    = (keep && burst_q != BURST_LAST) ? burst_q + 1'b1 : '0;
        pend_d     = any_gnt & ~bus.req_we_i[gnt_idx];
        pend_own_d = gnt_idx;
        bus.req_ready_o = gnt;
        csb0       = ~any_gnt;
        web0       = ~(any_gnt & bus.req_we_i[gnt_idx]);
        addr0      = any_gnt ? bus.req_addr_i[int'(gnt_idx) * ADDR_W +: ADDR_W] : '0;
        din0       = any_gnt ? bus.req_wdata_i[int'(gnt_idx) * DATA_W +: DATA_W] : '0;
        wmask0     = any_gnt ? bus.req_wmask_i[int'(gnt_idx) * MW +: MW] : '0;
        rsp_v      = pend_q & ~rst;
        bus.rsp_valid_o = rsp_v ? NUM_REQ'(1) << pend_own_q : '0;
        bus.rsp_rdata_o = rsp_v ? dout0 : '0;
        busy_o     = ~rst & (owned | pend_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= IW'(NUM_REQ - 1);
            burst_q    <= '0;
            pend_q     <= 1'b0;
            pend_own_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            pend_q     <= pend_d;
            pend_own_q <= pend_own_d;
        end
    end
endmodule
